// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {PCG_BOOT, PCG_RUN, PCG_HOLD} pcg_state_e;

  localparam logic [31:0] PCG_RESET_VEC = 32'h0000_0000;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC / next-state priority select for pc_gen_unit.
// Target alignment is enforced only when PC_GEN_ALIGN_CHK_EN is defined.
module pc_next_mux
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int INC  = 4
) (
  input  pcg_state_e       state,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  pend_pc,
  input  logic             stall_f,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             imem_ready,
  output pcg_state_e       nxt_state,
  output logic [XLEN-1:0]  nxt_pc,
  output logic [XLEN-1:0]  nxt_pend_pc,
  output logic             misalign
);

  logic            advance;
  logic            tgt_load;
  logic            seq_inc;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_aligned;

  assign advance = (state != PCG_BOOT) & ~stall_f & imem_ready;

  // Redirects and the pending release bypass the stall: a flush must not wait.
  always_comb begin
    nxt_state   = state;
    nxt_pend_pc = pend_pc;
    tgt         = redirect_pc;
    tgt_load    = 1'b0;
    seq_inc     = 1'b0;
    if (redirect && imem_ready) begin
      tgt_load    = 1'b1;
      nxt_pend_pc = '0;
      nxt_state   = PCG_RUN;
    end else if (redirect) begin
      nxt_pend_pc = redirect_pc;
      nxt_state   = PCG_HOLD;
    end else if (state == PCG_HOLD && imem_ready) begin
      tgt         = pend_pc;
      tgt_load    = 1'b1;
      nxt_pend_pc = '0;
      nxt_state   = PCG_RUN;
    end else if (state == PCG_BOOT) begin
      nxt_state   = PCG_RUN;
    end else if (advance) begin
      if (pred_taken) begin
        tgt      = pred_target;
        tgt_load = 1'b1;
      end else begin
        seq_inc  = 1'b1;
      end
    end
  end

`ifdef PC_GEN_ALIGN_CHK_EN
  assign tgt_aligned = {tgt[XLEN-1:2], tgt[1:0] & ~PC_ALIGN_MASK};
  assign misalign    = tgt_load & (|(tgt[1:0] & PC_ALIGN_MASK));
`else
  assign tgt_aligned = tgt;
  assign misalign    = 1'b0;
`endif

  always_comb begin
    nxt_pc = pc;
    if (tgt_load)
      nxt_pc = tgt_aligned;
    else if (seq_inc)
      nxt_pc = pc + XLEN'(INC);
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: boot bubble, predictor targets, redirect with pending latch.
// Optional macro PC_GEN_ALIGN_CHK_EN forces loaded targets word-aligned and flags it on o_misalign.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PCG_RESET_VEC),
  parameter int              INC       = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall_f,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_target,
  input  logic             i_imem_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic             o_pc_valid,
  output logic             o_imem_req,
  output logic             o_redirect_pending,
  output logic             o_misalign
);

  pcg_state_e      state, nxt_state;
  logic [XLEN-1:0] pc, nxt_pc;
  logic [XLEN-1:0] pend_pc, nxt_pend_pc;
  logic            misalign_d, misalign_q;

  pc_next_mux #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_next (
    .state       (state),
    .pc          (pc),
    .pend_pc     (pend_pc),
    .stall_f     (i_stall_f),
    .redirect    (i_redirect),
    .redirect_pc (i_redirect_pc),
    .pred_taken  (i_pred_taken),
    .pred_target (i_pred_target),
    .imem_ready  (i_imem_ready),
    .nxt_state   (nxt_state),
    .nxt_pc      (nxt_pc),
    .nxt_pend_pc (nxt_pend_pc),
    .misalign    (misalign_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= PCG_BOOT;
      pc         <= RESET_VEC;
      pend_pc    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state      <= nxt_state;
      pc         <= nxt_pc;
      pend_pc    <= nxt_pend_pc;
      misalign_q <= misalign_d;
    end
  end

  assign o_pc               = pc;
  assign o_pc_valid         = (state != PCG_BOOT);
  assign o_imem_req         = o_pc_valid & ~i_stall_f;
  assign o_redirect_pending = (state == PCG_HOLD);
  assign o_misalign         = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Randomized self-checking bench for pc_gen_unit against a behavioural fetch model.
module tb_pc_gen_unit;

  localparam int          XLEN = 32;
  localparam logic [31:0] RVEC = 32'h0000_0100;
  localparam int          INC  = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall_f = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_pred_taken = 1'b0;
  logic [31:0] i_pred_target = '0;
  logic        i_imem_ready = 1'b0;
  logic [31:0] o_pc;
  logic        o_pc_valid;
  logic        o_imem_req;
  logic        o_redirect_pending;
  logic        o_misalign;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetch has started, a redirect is parked, its target.
  logic [31:0] m_pc;
  logic        m_booted;
  logic        m_parked;
  logic [31:0] m_parked_pc;
  logic        m_mis;

  pc_gen_unit #(.XLEN(XLEN), .RESET_VEC(RVEC), .INC(INC)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_stall_f          (i_stall_f),
    .i_redirect         (i_redirect),
    .i_redirect_pc      (i_redirect_pc),
    .i_pred_taken       (i_pred_taken),
    .i_pred_target      (i_pred_target),
    .i_imem_ready       (i_imem_ready),
    .o_pc               (o_pc),
    .o_pc_valid         (o_pc_valid),
    .o_imem_req         (o_imem_req),
    .o_redirect_pending (o_redirect_pending),
    .o_misalign         (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RVEC; m_booted = 1'b0; m_parked = 1'b0; m_parked_pc = '0; m_mis = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] t);
`ifdef PC_GEN_ALIGN_CHK_EN
    m_pc  = {t[31:2], 2'b00};
    m_mis = (t % 4) != 0;
`else
    m_pc  = t;
    m_mis = 1'b0;
`endif
  endtask

  // One rising edge of the fetch rules applied to the held inputs.
  task automatic model_edge();
    m_mis = 1'b0;
    if (i_redirect && i_imem_ready) begin
      model_load(i_redirect_pc);
      m_parked = 1'b0; m_parked_pc = '0; m_booted = 1'b1;
    end else if (i_redirect) begin
      m_parked = 1'b1; m_parked_pc = i_redirect_pc; m_booted = 1'b1;
    end else if (m_parked && i_imem_ready) begin
      model_load(m_parked_pc);
      m_parked = 1'b0; m_parked_pc = '0;
    end else if (!m_booted) begin
      m_booted = 1'b1;
    end else if (!m_parked && !i_stall_f && i_imem_ready) begin
      if (i_pred_taken) model_load(i_pred_target);
      else m_pc = 32'((64'(m_pc) + INC) % 64'h1_0000_0000);
    end
  endtask

  task automatic check_all();
    chk("pc",      64'(o_pc),               64'(m_pc));
    chk("valid",   64'(o_pc_valid),         64'(m_booted));
    chk("req",     64'(o_imem_req),         64'(m_booted && !i_stall_f));
    chk("pending", 64'(o_redirect_pending), 64'(m_parked));
    chk("misal",   64'(o_misalign),         64'(m_mis));
  endtask

  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic pt, input logic [31:0] ptg, input logic rdy);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_stall_f = st; i_redirect = rd; i_redirect_pc = rpc;
    i_pred_taken = pt; i_pred_target = ptg; i_imem_ready = rdy;
    #1 check_all();
    @(posedge i_clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc",      64'(o_pc), 64'(RVEC));
    chk("rst_valid",   64'(o_pc_valid), 64'd0);
    chk("rst_req",     64'(o_imem_req), 64'd0);
    chk("rst_pending", 64'(o_redirect_pending), 64'd0);
    chk("rst_misal",   64'(o_misalign), 64'd0);
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    model_reset();
    #12;
    chk("por_pc",    64'(o_pc), 64'(RVEC));
    chk("por_valid", 64'(o_pc_valid), 64'd0);
    chk("por_req",   64'(o_imem_req), 64'd0);

    // Boot bubble then sequential fetch.
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    #1 chk("seq_pc", 64'(o_pc), 64'h108);

    // Predicted-taken held off by stall.
    cyc(0, 1, 32'h200, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 1, 32'h400, 1);
    #1 chk("stall_hold", 64'(o_pc), 64'h200);
    cyc(0, 0, 0, 1, 32'h400, 1);
    #1 chk("pred_pc", 64'(o_pc), 64'h400);

    // Flush overrides stall.
    cyc(1, 1, 32'h800, 0, 0, 1);
    #1 chk("flush_pc", 64'(o_pc), 64'h800);

    // Newer parked redirect replaces the older one.
    cyc(0, 1, 32'h300, 0, 0, 0);
    cyc(0, 1, 32'h340, 0, 0, 0);
    #1 chk("park_hold", 64'(o_pc), 64'h800);
    cyc(0, 0, 0, 1, 32'h900, 0);
    cyc(1, 0, 0, 0, 0, 0);
    #1 chk("no300", 64'(o_pc == 32'h300), 64'd0);
    cyc(1, 0, 0, 0, 0, 1);
    #1 chk("park_rel", 64'(o_pc), 64'h340);
    chk("park_clr", 64'(o_redirect_pending), 64'd0);

    // Wraparound.
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    #1 chk("wrap_pc", 64'(o_pc), 64'h0);

    // Misaligned redirect.
    cyc(0, 1, 32'h1002, 0, 0, 1);
`ifdef PC_GEN_ALIGN_CHK_EN
    #1 chk("mis_pc", 64'(o_pc), 64'h1000);
    chk("mis_flag", 64'(o_misalign), 64'd1);
`else
    #1 chk("mis_pc", 64'(o_pc), 64'h1002);
    chk("mis_flag", 64'(o_misalign), 64'd0);
`endif
    cyc(0, 0, 0, 0, 0, 1);
    #1 chk("mis_pulse", 64'(o_misalign), 64'd0);

    // Reset while a redirect is parked.
    cyc(0, 1, 32'h500, 0, 0, 0);
    #1 chk("hold_pend", 64'(o_redirect_pending), 64'd1);
    do_reset();
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    #1 chk("post_rst_pc", 64'(o_pc), 64'h108);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, rnd_tgt(),
          $urandom_range(0, 2) == 0, rnd_tgt(), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised fetch-stage program-counter generator, successor to the plain PC register.
- Sequential increment, predictor-driven target.
- Execute-stage redirect with priority and a pending-redirect latch when instruction memory is busy.
- Sits between branch predictor / hazard unit and instruction memory; o_pc feeds IMEM address and the IF/ID register.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits)
INC, 4, sequential increment in bytes

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_stall_f  input  1  hazard-unit fetch stall
i_redirect  input  1  execute-stage mispredict/jump redirect valid
i_redirect_pc  input  XLEN  redirect target
i_pred_taken  input  1  predictor says taken for current o_pc
i_pred_target  input  XLEN  predicted target
i_imem_ready  input  1  IMEM accepts a new address this cycle
o_pc  output  XLEN  current fetch PC
o_pc_valid  output  1  o_pc is a real fetch (0 during boot bubble)
o_imem_req  output  1  fetch request to IMEM
o_redirect_pending  output  1  latched redirect not yet applied
o_misalign  output  1  misaligned target flag (see Optional Feature)

Behaviour:
- Reset (async, while i_rst_n=0):
  - o_pc=RESET_VEC, state=BOOT, pending register cleared (valid=0, pc=0).
  - o_pc_valid=0, o_imem_req=0, o_redirect_pending=0, o_misalign=0.
- States: BOOT, RUN, HOLD.
  - BOOT: exactly one cycle after reset release. o_pc stays RESET_VEC. Next: RUN.
  - RUN: normal fetch.
  - HOLD: a redirect is latched and waiting for i_imem_ready.
- o_pc_valid=1 in RUN and HOLD.
- o_imem_req = o_pc_valid & ~i_stall_f, combinational.
- advance = (state!=BOOT) & ~i_stall_f & i_imem_ready.
- Next-PC priority, highest first:
  1. i_redirect & i_imem_ready: o_pc<=i_redirect_pc. Applied even when i_stall_f=1; flush overrides stall. Any pending redirect is discarded. Next state RUN.
  2. i_redirect & ~i_imem_ready: pending<=i_redirect_pc, state HOLD, o_pc unchanged. A newer redirect overwrites an older pending one.
  3. HOLD & i_imem_ready & ~i_redirect: o_pc<=pending, pending cleared, state RUN. Stall is ignored, as in case 1.
  4. advance & i_pred_taken: o_pc<=i_pred_target.
  5. advance: o_pc<=o_pc+INC, modulo 2^XLEN; wraps to 0 with no flag.
  6. Otherwise o_pc holds.
- o_redirect_pending = (state==HOLD), registered.
- Predictor input is ignored in BOOT and HOLD.
- Latency: redirect visible on o_pc the cycle after the accepting edge. Sequential advance is one cycle per accepted fetch.
- Reset mid-HOLD: pending is lost and fetch restarts at RESET_VEC.

Optional Feature:
Macro PC_GEN_ALIGN_CHK_EN.
- Defined:
  - Any target about to be loaded (redirect, pending, predicted) with bits [1:0]!=0 gets its low two bits forced to 0 before loading.
  - o_misalign pulses high for exactly the cycle after that load. It is a registered output, reset 0.
- Undefined: o_misalign tied 0; targets loaded unmodified.

Decomposition:
- Shared package pc_gen_pkg:
  - typedef enum logic [1:0] {PCG_BOOT, PCG_RUN, PCG_HOLD} pcg_state_e.
  - localparam default RESET_VEC.
  - localparam PC_ALIGN_MASK.
- One natural sub-module, pc_next_mux: purely combinational priority select of next PC and next state. The top holds the o_pc flop, state flop, pending flop and o_misalign flop.

Test Plan:
- Reset with RESET_VEC=32'h100, ready=1, no stall -> o_pc 0x100 for boot cycle (valid=0), then 0x104, 0x108; valid=1 from cycle 2.
- o_pc=0x200, i_pred_taken=1 with target 0x400, i_stall_f=1 for 2 cycles then 0 -> o_pc holds 0x200 for both stalled cycles, then 0x400.
- i_stall_f=1 and i_redirect=1 to 0x800 with ready=1 -> o_pc=0x800 next cycle despite stall.
- ready=0, redirect 0x300 then redirect 0x340 while still not ready, ready=1 two cycles later -> o_redirect_pending=1 throughout, o_pc unchanged until ready, then 0x340; 0x300 never appears.
- o_pc=32'hFFFF_FFFC with advance -> o_pc=0; async reset asserted during HOLD -> immediate RESET_VEC, pending=0.
- With PC_GEN_ALIGN_CHK_EN: redirect 0x1002 -> o_pc=0x1000, o_misalign=1 for one cycle. Without the macro: o_pc=0x1002, o_misalign=0.
